// File: rtl/grad_step_update_pkg.sv
// Shared fixed-point constants and FSM encoding
// for the gradient-step update block.
package gd_fixed_pkg;
  localparam int WORD_W      = 16;
  localparam int FRAC_BITS   = 8;
  localparam int DIM_DEFAULT = 4;

  localparam logic [WORD_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [WORD_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } gd_state_t;
endpackage

// File: rtl/grad_step_update_if.sv
// Request/result handshake bundle between the
// gradient-step block and its neighbours.
interface grad_step_update_if
  import gd_fixed_pkg::*;
#(
  parameter int DIM = DIM_DEFAULT
);
  logic                    in_valid;
  logic                    in_ready;
  logic [WORD_W*DIM-1:0]   pos_in;
  logic [WORD_W*DIM-1:0]   grad_in;
  logic [2:0]              lr_shift;
  logic                    out_valid;
  logic                    out_ready;
  logic [WORD_W*DIM-1:0]   pos_out;
  logic                    converged;
  logic                    busy;

  modport master (
    output in_valid, pos_in, grad_in, lr_shift, out_ready,
    input  in_ready, out_valid, pos_out, converged, busy
  );

  modport slave (
    input  in_valid, pos_in, grad_in, lr_shift, out_ready,
    output in_ready, out_valid, pos_out, converged, busy
  );
endinterface

// File: rtl/grad_step_update_sat_sub16.sv
// Signed 16-bit subtract a - b, evaluated in 17 bits
// and clamped to the 16-bit signed range.
module sat_sub16
  import gd_fixed_pkg::*;
(
  input  logic signed [WORD_W-1:0] i_a,
  input  logic signed [WORD_W-1:0] i_b,
  output logic        [WORD_W-1:0] o_y
);
  logic signed [WORD_W:0] w_diff;

  assign w_diff = {i_a[WORD_W-1], i_a} - {i_b[WORD_W-1], i_b};

  always_comb begin
    o_y = w_diff[WORD_W-1:0];
    if (w_diff[WORD_W] != w_diff[WORD_W-1])
      o_y = w_diff[WORD_W] ? SAT_MIN : SAT_MAX;
  end
endmodule

// File: rtl/grad_step_update.sv
// One gradient-descent step pos -= grad * 2^-lr,
// one coordinate per clock through a shared saturating subtractor.
module grad_step_update
  import gd_fixed_pkg::*;
#(
  parameter int          DIM         = DIM_DEFAULT,
  parameter logic [15:0] CONV_THRESH = 16'h0010
) (
  input  logic               clk,
  input  logic               rst,
  grad_step_update_if.slave  io
);
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;

  gd_state_t r_state;
  gd_state_t w_next;

  logic [DIM-1:0][WORD_W-1:0] r_pos;
  logic [DIM-1:0][WORD_W-1:0] r_grad;
  logic [2:0]                 r_lr;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_conv;

  logic signed [WORD_W-1:0] w_step;
  logic        [WORD_W:0]   w_step17;
  logic        [WORD_W:0]   w_mag;
  logic        [WORD_W-1:0] w_sub;
  logic                     w_last;

  assign w_step   = $signed(r_grad[r_idx]) >>> r_lr;
  assign w_step17 = {w_step[WORD_W-1], w_step};
  // Magnitude kept in 17 bits so that |-32768| does not wrap.
  assign w_mag    = w_step[WORD_W-1] ? (~w_step17 + 1'b1) : w_step17;
  assign w_last   = (r_idx == IDX_W'(DIM - 1));

  sat_sub16 u_sub (
    .i_a (r_pos[r_idx]),
    .i_b (w_step),
    .o_y (w_sub)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        io.in_ready = ~rst;
        if (io.in_valid) w_next = S_CALC;
      end
      S_CALC: begin
        io.busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        io.busy      = 1'b1;
        io.out_valid = 1'b1;
        if (io.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos  <= '0;
      r_grad <= '0;
      r_lr   <= '0;
      r_idx  <= '0;
      r_conv <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (io.in_valid) begin
            r_pos  <= io.pos_in;
            r_grad <= io.grad_in;
            r_lr   <= io.lr_shift;
            r_idx  <= '0;
            r_conv <= 1'b1;
          end
        end
        S_CALC: begin
          r_pos[r_idx] <= w_sub;
          r_idx        <= r_idx + 1'b1;
          if (w_mag > {1'b0, CONV_THRESH}) r_conv <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io.pos_out   = r_pos;
  assign io.converged = r_conv;
endmodule

// File: tb/tb_grad_step_update.sv
// Randomized and directed checks of grad_step_update
// against an integer-arithmetic reference model.
module tb_grad_step_update;
  import gd_fixed_pkg::*;

  localparam int          DIM = 4;
  localparam logic [15:0] TH  = 16'h0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grad_step_update_if #(.DIM(DIM)) bus ();

  grad_step_update #(
    .DIM         (DIM),
    .CONV_THRESH (TH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] pv [DIM];
  logic [15:0] gv [DIM];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int floor_div_pow2(int g, int s);
    int d;
    d = 1 << s;
    if (g >= 0) return g / d;
    return -((-g + d - 1) / d);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input int s, input int hold);
    logic [63:0] exp_pos;
    logic        exp_conv;
    int          st, d, lat, w;
    exp_pos  = '0;
    exp_conv = 1'b1;
    for (int i = 0; i < DIM; i++) begin
      st = floor_div_pow2(int'($signed(gv[i])), s);
      d  = int'($signed(pv[i])) - st;
      if (d > 32767)  d = 32767;
      if (d < -32768) d = -32768;
      exp_pos[16*i +: 16] = d[15:0];
      if ((st < 0 ? -st : st) > int'(TH)) exp_conv = 1'b0;
    end
    w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < DIM; i++) begin
      bus.pos_in[16*i +: 16]  = pv[i];
      bus.grad_in[16*i +: 16] = gv[i];
    end
    bus.lr_shift = 3'(s);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 3 * DIM) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(DIM));
    check({tag, "_pos"}, bus.pos_out, exp_pos);
    check({tag, "_conv"}, 64'(bus.converged), 64'(exp_conv));
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.pos_in   = {$urandom, $urandom};
      bus.grad_in  = {$urandom, $urandom};
      tick();
      check({tag, "_hv"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hr"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_hp"}, bus.pos_out, exp_pos);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, {62'd0, bus.out_valid, bus.in_ready}, 64'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.pos_in    = '0;
    bus.grad_in   = '0;
    bus.lr_shift  = '0;
    repeat (3) tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_pos", bus.pos_out, 64'd0);
    check("rst_conv", 64'(bus.converged), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < DIM; i++) begin
      pv[i] = 16'h0100;
      gv[i] = 16'h0200;
    end
    run_vec("basic", 1, 0);

    for (int i = 0; i < DIM; i++) begin
      pv[i] = '0;
      gv[i] = '0;
    end
    pv[0] = 16'h7F00; gv[0] = 16'h8000;
    pv[1] = 16'h8100; gv[1] = 16'h7FFF;
    run_vec("sat", 0, 0);

    for (int i = 0; i < DIM; i++) gv[i] = 16'h0010;
    run_vec("conv_eq", 0, 0);
    gv[2] = 16'h0011;
    run_vec("conv_gt", 0, 0);
    gv[2] = 16'h0010;
    gv[3] = 16'h8000;
    run_vec("conv_min", 0, 0);

    for (int i = 0; i < DIM; i++) begin
      pv[i] = '0;
      gv[i] = '0;
    end
    gv[0] = 16'hFFFF;
    run_vec("floor", 4, 0);

    for (int i = 0; i < DIM; i++) begin
      pv[i] = 16'(i * 16'h0123);
      gv[i] = 16'(16'h0400 - i * 16'h0300);
    end
    run_vec("hold", 2, 10);

    bus.pos_in   = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bus.grad_in  = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
    bus.lr_shift = 3'd1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    check("abort_pos_rst", bus.pos_out, 64'd0);
    check("abort_rdy_rst", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("abort_ready", 64'(bus.in_ready), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    for (int k = 0; k < DIM + 2; k++) begin
      tick();
      check("abort_ov", 64'(bus.out_valid), 64'd0);
    end
    check("abort_pos", bus.pos_out, 64'd0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DIM; i++) begin
        pv[i] = 16'($urandom);
        gv[i] = ($urandom_range(0, 2) == 0) ?
                16'($urandom_range(0, 64)) - 16'd32 : 16'($urandom);
      end
      run_vec("rand", int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/grad_step_update.md
GRAD_STEP_UPDATE -- requirements
Module: grad_step_update

Interface
REQ-001 SHALL have parameter DIM, default 4, number of coordinates per vector.
REQ-002 SHALL have parameter CONV_THRESH, default 16'h0010 (1/16 in 8.8), convergence bound on |step|.
REQ-003 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request carries a valid position/gradient set.
REQ-006 SHALL have port in_ready, output, 1, block accepts a request this cycle.
REQ-007 SHALL have port pos_in, input, 16*DIM, signed 8.8 positions; coordinate i in bits [16i+15:16i].
REQ-008 SHALL have port grad_in, input, 16*DIM, signed 8.8 gradients, same packing.
REQ-009 SHALL have port lr_shift, input, 3, learning rate = 2^-lr_shift (0..7).
REQ-010 SHALL have port out_valid, output, 1, pos_out/converged are valid.
REQ-011 SHALL have port out_ready, input, 1, downstream (integer snapping stage) accepts result.
REQ-012 SHALL have port pos_out, output, 16*DIM, updated signed 8.8 positions, same packing.
REQ-013 SHALL have port converged, output, 1, every |step| <= CONV_THRESH; meaningful only with out_valid.
REQ-014 SHALL have port busy, output, 1, high in CALC or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready SHALL register pos_in, grad_in, lr_shift, clear idx to 0, set conv flag to 1, go to CALC.
REQ-017 CALC: in_ready=0; each edge SHALL process coordinate idx: step = grad[idx] >>> lr_shift (arithmetic, floor), pos[idx] <= sat16(pos[idx] - step) computed in 17 bits.
REQ-018 sat16 SHALL clamp to 16'h7FFF above +32767 and 16'h8000 below -32768.
REQ-019 CALC SHALL clear conv flag when |step| (17-bit magnitude, so |-32768| = 32768) > CONV_THRESH; flag is sticky for the vector.
REQ-020 CALC SHALL increment idx each edge and go to DONE on the edge processing idx=DIM-1.
REQ-021 Latency SHALL be exactly DIM edges: out_valid high after the DIM-th rising edge following the accepting edge.
REQ-022 DONE: out_valid=1, pos_out and converged SHALL be held stable until out_valid&&out_ready, then go to IDLE.
REQ-023 in_valid outside IDLE SHALL be ignored; no input is queued.
REQ-024 pos_out SHALL be the register file directly; unprocessed coordinates are never visible with out_valid=1.
REQ-025 in_ready SHALL not depend combinationally on out_ready (no IDLE bypass from DONE).

Reset
REQ-026 rst SHALL asynchronously force state IDLE, idx 0, pos/grad/lr registers 0, conv flag 0.
REQ-027 During reset: in_ready=0 (held low while rst high), out_valid=0, pos_out=0, converged=0, busy=0.
REQ-028 Reset mid-CALC or mid-DONE SHALL abort the vector with no output; in_ready=1 on first cycle after release.

Structure
REQ-029 Shared package gd_fixed_pkg SHALL hold WORD_W=16, FRAC_BITS=8, DIM default, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000, FSM state enum.
REQ-030 Saturating subtract SHALL be sub-module sat_sub16 (two 16-bit signed in, 16-bit saturated out); one instance, time-multiplexed by idx.

Verification
REQ-031 pos all 16'h0100, grad all 16'h0200, lr_shift=1 -> pos_out all 16'h0000, converged=0, out_valid after 4th edge post-accept.
REQ-032 pos0=16'h7F00, grad0=16'h8000, lr_shift=0 -> pos_out[0]=16'h7FFF; pos1=16'h8100, grad1=16'h7FFF -> pos_out[1]=16'h8000.
REQ-033 all grads 16'h0010, lr_shift=0 -> converged=1; one grad 16'h0011 -> converged=0; grad 16'h8000, lr_shift=0 -> converged=0.
REQ-034 grad0=16'hFFFF, lr_shift=4, pos0=16'h0000 -> step=-1, pos_out[0]=16'h0001.
REQ-035 out_ready low 10 cycles in DONE with in_valid high -> pos_out, out_valid held, in_ready=0, no new capture.
REQ-036 rst pulse on 2nd CALC edge -> out_valid never rises, pos_out=0, in_ready=1 first cycle after release.
